net_tx_owner_arbiter: RTL and testbench
=======================================

Name: net_tx_owner_arbiter

Overview:
- Shares the single outbound AXI-Stream TX path (O) between the trusted (T) and untrusted (U) network domains.
- Ownership changes only at packet boundaries, followed by a mandatory idle quiesce gap.
- Exports a `trusted` status that is stable except on the ownership-change edge.
- Sits between the T/U TX streams and the network interface; its switch requests come from the arbiter control register path.

Parameters:
- DATA_W, 32, tdata width; tkeep width is DATA_W/8.
- GAP_CYCLES, 4, idle cycles between old-owner release and new-owner grant; minimum 1.
- DRAIN_TIMEOUT, 1024, maximum DRAIN cycles before forced abort; used only with the optional feature.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- switch_req  in  1  single-cycle switch request
- switch_to_trusted  in  1  requested owner (1=T, 0=U), sampled with switch_req
- trusted  out  1  current owner (1=T)
- busy  out  1  switch in progress (DRAIN/GAP/ABORT)
- abort_pulse  out  1  one-cycle pulse when a packet is force-terminated
- T_tdata/T_tkeep/T_tlast/T_tvalid  in  DATA_W/DATA_W/8/1/1  trusted TX stream
- T_tready  out  1
- U_tdata/U_tkeep/U_tlast/U_tvalid  in  DATA_W/DATA_W/8/1/1  untrusted TX stream
- U_tready  out  1
- O_tdata/O_tkeep/O_tlast/O_tvalid  out  DATA_W/DATA_W/8/1/1  shared TX output
- O_tready  in  1

Behaviour:
- Reset: clk rising edge; resetn synchronous, active-low.
  - Reset values: state=OWN, trusted=1, in_pkt=0, busy=0, abort_pulse=0, counters=0.
  - Stream outputs: O_tvalid=0, T_tready=0, U_tready=0.
  - Reset mid-packet or mid-switch discards all progress; no terminating beat is emitted.
- in_pkt tracks the owner's stream only:
  - Set on an owner handshake with tlast=0.
  - Cleared on an owner handshake with tlast=1.
- Passthrough (combinational) when the state is OWN, or DRAIN with in_pkt=1:
  - O_tdata/tkeep/tlast/tvalid = owner's signals.
  - owner tready = O_tready.
- Otherwise O_tvalid=0 and owner tready=0.
- The non-owner tready is always 0.
- States:
  - OWN:
    - switch_req with switch_to_trusted != trusted -> DRAIN, busy=1 next cycle.
    - switch_req with switch_to_trusted == trusted is ignored.
  - DRAIN:
    - No new packet may start.
    - When in_pkt=0 (including when tlast is accepted in the same cycle) -> GAP, loading gap_cnt=GAP_CYCLES-1.
  - GAP:
    - All stream outputs are idle.
    - gap_cnt decrements each cycle.
    - At gap_cnt==0 -> OWN; trusted flips on the same edge and busy clears.
  - ABORT: optional feature only.
- switch_req while busy=1 is ignored; it is neither queued nor acknowledged.
- A request in the same cycle as the owner's last beat: the beat completes; next cycle is DRAIN, which sees in_pkt=0 and moves to GAP.
- Latency, idle owner, request at cycle 0:
  - DRAIN at cycle 1, GAP at cycles 2..GAP_CYCLES+1.
  - trusted flips and the new owner gets access at cycle GAP_CYCLES+2.
- A drain in progress waits indefinitely for O_tready/tlast (without the optional feature).

Optional Feature:
- Macro: NET_ARB_DRAIN_TIMEOUT_EN.
- With the macro:
  - drain_cnt counts DRAIN cycles.
  - If drain_cnt reaches DRAIN_TIMEOUT with in_pkt=1 -> ABORT.
- ABORT state:
  - Owner tready=0.
  - O_tvalid=1, O_tlast=1, O_tkeep=0, O_tdata=0, held until O_tready.
  - Then in_pkt is cleared, abort_pulse=1 for that cycle, and the state moves to GAP.
- Without the macro: no drain_cnt, no ABORT state, abort_pulse tied 0.

Decomposition:
- Package net_arb_pkg:
  - State enum {OWN, DRAIN, GAP, ABORT}.
  - Default DATA_W.
  - Counter width constants, derived via $clog2 of GAP_CYCLES and DRAIN_TIMEOUT.
- Sub-module axis_pkt_tracker: computes in_pkt from valid/ready/last with a clear input; reused for the RX direction later.

Test Plan:
- Reset, then T sends 3-beat packet with O_tready=1 -> all 3 beats on O, trusted=1, U_tready=0 throughout.
- T mid-packet (beat 2 of 4); switch_req to U -> remaining 2 beats pass; GAP_CYCLES=4 idle cycles; then trusted=0 and U packet passes.
- switch_req to T while T already owns -> busy stays 0, no gap, traffic uninterrupted.
- Second switch_req during GAP -> ignored; owner changes exactly once.
- With NET_ARB_DRAIN_TIMEOUT_EN and DRAIN_TIMEOUT=8: T stalls mid-packet (tvalid=0) after switch_req -> at 8 cycles one beat tlast=1, tkeep=0; abort_pulse=1; then GAP; then trusted=0.
- resetn=0 during GAP -> next cycle trusted=1, busy=0, O_tvalid=0, in_pkt=0.

Source files
------------

// File: rtl/net_arb_pkg.sv
// Shared types and sizing helpers for the network TX owner arbiter.
package net_arb_pkg;

  typedef enum logic [1:0] {
    OWN   = 2'd0,
    DRAIN = 2'd1,
    GAP   = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam int NET_ARB_DATA_W        = 32;
  localparam int NET_ARB_GAP_CYCLES    = 4;
  localparam int NET_ARB_DRAIN_TIMEOUT = 1024;

  // Width of a down/up counter whose largest value is n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int NET_ARB_GAP_CNT_W   = cnt_width(NET_ARB_GAP_CYCLES);
  localparam int NET_ARB_DRAIN_CNT_W = cnt_width(NET_ARB_DRAIN_TIMEOUT);

endpackage

// File: rtl/axis_pkt_tracker.sv
// Tracks whether an AXI-Stream is between the first and last beat of a packet.
module axis_pkt_tracker (
  input  logic clk,
  input  logic resetn,
  input  logic i_valid,
  input  logic i_ready,
  input  logic i_last,
  input  logic i_clear,
  output logic o_in_pkt
);

  logic r_in_pkt;

  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_in_pkt <= 1'b0;
    end else if (i_valid && i_ready) begin
      r_in_pkt <= !i_last;
    end
  end

  assign o_in_pkt = r_in_pkt;

endmodule

// File: rtl/net_tx_owner_arbiter.sv
// Packet-boundary ownership switch of the shared TX stream between trusted and untrusted domains.
// Optional drain timeout with forced packet abort: define NET_ARB_DRAIN_TIMEOUT_EN.
module net_tx_owner_arbiter
  import net_arb_pkg::*;
#(
  parameter int DATA_W        = NET_ARB_DATA_W,
  parameter int GAP_CYCLES    = NET_ARB_GAP_CYCLES,
  parameter int DRAIN_TIMEOUT = NET_ARB_DRAIN_TIMEOUT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                switch_req,
  input  logic                switch_to_trusted,
  output logic                trusted,
  output logic                busy,
  output logic                abort_pulse,
  input  logic [DATA_W-1:0]   T_tdata,
  input  logic [DATA_W/8-1:0] T_tkeep,
  input  logic                T_tlast,
  input  logic                T_tvalid,
  output logic                T_tready,
  input  logic [DATA_W-1:0]   U_tdata,
  input  logic [DATA_W/8-1:0] U_tkeep,
  input  logic                U_tlast,
  input  logic                U_tvalid,
  output logic                U_tready,
  output logic [DATA_W-1:0]   O_tdata,
  output logic [DATA_W/8-1:0] O_tkeep,
  output logic                O_tlast,
  output logic                O_tvalid,
  input  logic                O_tready
);

  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1 || DRAIN_TIMEOUT < 1) begin : g_param_check
    $error("net_tx_owner_arbiter: GAP_CYCLES and DRAIN_TIMEOUT must be >= 1");
  end

  arb_state_t         r_state;
  logic               r_trusted;
  logic               r_busy;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic [DATA_W-1:0]   w_own_tdata;
  logic [DATA_W/8-1:0] w_own_tkeep;
  logic                w_own_tlast;
  logic                w_own_tvalid;
  logic                w_own_tready;
  logic                w_own_hs;
  logic                w_in_pkt;
  logic                w_pass;
  logic                w_abort;
  logic                w_clear;

  always_comb begin
    w_own_tdata  = r_trusted ? T_tdata  : U_tdata;
    w_own_tkeep  = r_trusted ? T_tkeep  : U_tkeep;
    w_own_tlast  = r_trusted ? T_tlast  : U_tlast;
    w_own_tvalid = r_trusted ? T_tvalid : U_tvalid;
  end

  // Outputs stay idle while resetn is held low, regardless of the current state.
  assign w_pass = resetn && ((r_state == OWN) || (r_state == DRAIN && w_in_pkt));

`ifdef NET_ARB_DRAIN_TIMEOUT_EN
  localparam int DRAIN_W = cnt_width(DRAIN_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_abort_pulse;
  assign w_abort     = resetn && (r_state == ABORT);
  assign abort_pulse = r_abort_pulse;
`else
  assign w_abort     = 1'b0;
  assign abort_pulse = 1'b0;
`endif

  assign w_own_tready = w_pass && O_tready;
  assign w_own_hs     = w_own_tvalid && w_own_tready;
  assign w_clear      = w_abort && O_tready;

  assign T_tready = r_trusted  && w_own_tready;
  assign U_tready = !r_trusted && w_own_tready;

  assign O_tvalid = (w_pass && w_own_tvalid) || w_abort;
  assign O_tlast  = w_pass ? w_own_tlast : w_abort;
  assign O_tdata  = w_pass ? w_own_tdata : '0;
  assign O_tkeep  = w_pass ? w_own_tkeep : '0;

  assign trusted = r_trusted;
  assign busy    = r_busy;

  axis_pkt_tracker u_tracker (
    .clk      (clk),
    .resetn   (resetn),
    .i_valid  (w_own_tvalid),
    .i_ready  (w_own_tready),
    .i_last   (w_own_tlast),
    .i_clear  (w_clear),
    .o_in_pkt (w_in_pkt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= OWN;
      r_trusted <= 1'b1;
      r_busy    <= 1'b0;
      r_gap_cnt <= '0;
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
      r_drain_cnt   <= '0;
      r_abort_pulse <= 1'b0;
`endif
    end else begin
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
      r_abort_pulse <= 1'b0;
`endif
      case (r_state)
        OWN: begin
          if (switch_req && (switch_to_trusted != r_trusted)) begin
            r_state <= DRAIN;
            r_busy  <= 1'b1;
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
            r_drain_cnt <= '0;
`endif
          end
        end
        DRAIN: begin
          // A last beat accepted this cycle already ends the packet.
          if (!w_in_pkt || (w_own_hs && w_own_tlast)) begin
            r_state   <= GAP;
            r_gap_cnt <= GAP_LOAD;
          end
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
          else if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= ABORT;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (r_gap_cnt == '0) begin
            r_state   <= OWN;
            r_trusted <= !r_trusted;
            r_busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
        ABORT: begin
          if (O_tready) begin
            r_state       <= GAP;
            r_gap_cnt     <= GAP_LOAD;
            r_abort_pulse <= 1'b1;
          end
        end
`endif
        default: r_state <= OWN;
      endcase
    end
  end

endmodule

// File: tb/tb_net_tx_owner_arbiter.sv
// Directed bench for net_tx_owner_arbiter (GAP_CYCLES=4, DRAIN_TIMEOUT=8).
module tb_net_tx_owner_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        switch_req, switch_to_trusted;
  logic        trusted, busy, abort_pulse;
  logic [31:0] T_tdata, U_tdata, O_tdata;
  logic [3:0]  T_tkeep, U_tkeep, O_tkeep;
  logic        T_tlast, T_tvalid, T_tready;
  logic        U_tlast, U_tvalid, U_tready;
  logic        O_tlast, O_tvalid, O_tready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  net_tx_owner_arbiter #(.DATA_W(32), .GAP_CYCLES(4), .DRAIN_TIMEOUT(8)) u_dut (
    .clk(clk), .resetn(resetn), .switch_req(switch_req), .switch_to_trusted(switch_to_trusted),
    .trusted(trusted), .busy(busy), .abort_pulse(abort_pulse),
    .T_tdata(T_tdata), .T_tkeep(T_tkeep), .T_tlast(T_tlast), .T_tvalid(T_tvalid), .T_tready(T_tready),
    .U_tdata(U_tdata), .U_tkeep(U_tkeep), .U_tlast(U_tlast), .U_tvalid(U_tvalid), .U_tready(U_tready),
    .O_tdata(O_tdata), .O_tkeep(O_tkeep), .O_tlast(O_tlast), .O_tvalid(O_tvalid), .O_tready(O_tready)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 0; switch_req = 0; switch_to_trusted = 0; O_tready = 1;
    T_tdata = 32'h1234_5678; T_tkeep = 4'hF; T_tlast = 0; T_tvalid = 1;
    U_tdata = 32'h8765_4321; U_tkeep = 4'hF; U_tlast = 0; U_tvalid = 1;
    cyc(); cyc(); #1;
    checks++; if (trusted !== 1'b1) begin errors++; $display("FAIL rst_trusted got %b exp 1", trusted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (abort_pulse !== 1'b0) begin errors++; $display("FAIL rst_abort got %b exp 0", abort_pulse); end
    checks++; if (O_tvalid !== 1'b0) begin errors++; $display("FAIL rst_ovalid got %b exp 0", O_tvalid); end
    checks++; if ({T_tready, U_tready} !== 2'b00) begin errors++; $display("FAIL rst_treadys got %b exp 00", {T_tready, U_tready}); end
    cyc();
  endtask

  task automatic test_passthrough();
    resetn = 1; U_tdata = 32'hDEAD_0000; U_tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      T_tvalid = 1; T_tdata = 32'hA000_0000 + i; T_tkeep = 4'hF; T_tlast = (i == 2);
      #1;
      checks++; if (O_tvalid !== 1'b1 || O_tdata !== 32'hA000_0000 + i) begin errors++; $display("FAIL pt_beat%0d got v=%b d=%h exp v=1 d=%h", i, O_tvalid, O_tdata, 32'hA000_0000 + i); end
      checks++; if (O_tlast !== (i == 2)) begin errors++; $display("FAIL pt_last%0d got %b exp %b", i, O_tlast, (i == 2)); end
      checks++; if ({T_tready, U_tready, trusted} !== 3'b101) begin errors++; $display("FAIL pt_ready%0d got T=%b U=%b tr=%b exp 1 0 1", i, T_tready, U_tready, trusted); end
      cyc();
    end
    T_tvalid = 0; U_tvalid = 0; #1;
    checks++; if (O_tvalid !== 1'b0) begin errors++; $display("FAIL pt_idle got %b exp 0", O_tvalid); end
    cyc();
  endtask

  task automatic test_same_owner();
    T_tvalid = 1; T_tdata = 32'hB000_0000; T_tlast = 0; switch_req = 1; switch_to_trusted = 1; #1;
    checks++; if (O_tdata !== 32'hB000_0000) begin errors++; $display("FAIL same_b0 got %h exp b0000000", O_tdata); end
    cyc();
    switch_req = 0; T_tdata = 32'hB000_0001; T_tlast = 1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_busy got %b exp 0", busy); end
    checks++; if (O_tvalid !== 1'b1 || O_tdata !== 32'hB000_0001 || T_tready !== 1'b1) begin errors++; $display("FAIL same_b1 got v=%b d=%h rdy=%b exp 1 b0000001 1", O_tvalid, O_tdata, T_tready); end
    cyc();
    T_tvalid = 0; #1;
    checks++; if (busy !== 1'b0 || trusted !== 1'b1) begin errors++; $display("FAIL same_after got busy=%b tr=%b exp 0 1", busy, trusted); end
    cyc();
  endtask

  task automatic test_switch_mid_packet();
    T_tvalid = 1; T_tdata = 32'hC000_0000; T_tlast = 0; #1; cyc();
    T_tdata = 32'hC000_0001; switch_req = 1; switch_to_trusted = 0; #1;
    checks++; if (O_tdata !== 32'hC000_0001) begin errors++; $display("FAIL sw_c1 got %h exp c0000001", O_tdata); end
    cyc();
    switch_req = 0; T_tdata = 32'hC000_0002; #1;
    checks++; if (busy !== 1'b1 || O_tvalid !== 1'b1 || O_tdata !== 32'hC000_0002 || T_tready !== 1'b1) begin errors++; $display("FAIL sw_c2 got busy=%b v=%b d=%h rdy=%b exp 1 1 c0000002 1", busy, O_tvalid, O_tdata, T_tready); end
    cyc();
    T_tdata = 32'hC000_0003; T_tlast = 1; #1;
    checks++; if (O_tdata !== 32'hC000_0003 || O_tlast !== 1'b1) begin errors++; $display("FAIL sw_c3 got d=%h l=%b exp c0000003 1", O_tdata, O_tlast); end
    cyc();
    T_tdata = 32'hD000_0000; T_tlast = 0; U_tvalid = 1; U_tdata = 32'hE000_0000; U_tlast = 0; U_tkeep = 4'h3;
    for (int g = 0; g < 4; g++) begin
      #1;
      checks++; if ({O_tvalid, T_tready, U_tready} !== 3'b000) begin errors++; $display("FAIL sw_gap%0d got v=%b T=%b U=%b exp 0 0 0", g, O_tvalid, T_tready, U_tready); end
      checks++; if (busy !== 1'b1 || trusted !== 1'b1) begin errors++; $display("FAIL sw_gapst%0d got busy=%b tr=%b exp 1 1", g, busy, trusted); end
      cyc();
    end
    T_tvalid = 0; #1;
    checks++; if (trusted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sw_flip got tr=%b busy=%b exp 0 0", trusted, busy); end
    checks++; if (O_tvalid !== 1'b1 || O_tdata !== 32'hE000_0000 || O_tkeep !== 4'h3 || U_tready !== 1'b1 || T_tready !== 1'b0) begin errors++; $display("FAIL sw_u0 got v=%b d=%h k=%h U=%b T=%b exp 1 e0000000 3 1 0", O_tvalid, O_tdata, O_tkeep, U_tready, T_tready); end
    cyc();
    U_tdata = 32'hE000_0001; U_tlast = 1; #1;
    checks++; if (O_tdata !== 32'hE000_0001 || O_tlast !== 1'b1) begin errors++; $display("FAIL sw_u1 got d=%h l=%b exp e0000001 1", O_tdata, O_tlast); end
    cyc();
    U_tvalid = 0; U_tlast = 0;
  endtask

  task automatic test_gap_request_ignored();
    switch_req = 1; switch_to_trusted = 1; #1; cyc();
    switch_req = 0; U_tvalid = 1; U_tdata = 32'hF000_0000; U_tlast = 1; #1;
    checks++; if (busy !== 1'b1 || O_tvalid !== 1'b0 || U_tready !== 1'b0) begin errors++; $display("FAIL gq_drain got busy=%b v=%b U=%b exp 1 0 0", busy, O_tvalid, U_tready); end
    cyc();
    for (int k = 2; k < 6; k++) begin
      switch_req = (k == 3); switch_to_trusted = 0; #1;
      checks++; if (trusted !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gq_gap%0d got tr=%b busy=%b exp 0 1", k, trusted, busy); end
      cyc();
    end
    switch_req = 0; U_tvalid = 0; #1;
    checks++; if (trusted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL gq_flip got tr=%b busy=%b exp 1 0", trusted, busy); end
    repeat (8) cyc();
    checks++; if (trusted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL gq_once got tr=%b busy=%b exp 1 0", trusted, busy); end
  endtask

  task automatic test_reset_in_gap();
    switch_req = 1; switch_to_trusted = 0; #1; cyc();
    switch_req = 0; cyc(); cyc();
    resetn = 0; cyc();
    resetn = 1; #1;
    checks++; if (trusted !== 1'b1 || busy !== 1'b0 || O_tvalid !== 1'b0) begin errors++; $display("FAIL rg_after got tr=%b busy=%b v=%b exp 1 0 0", trusted, busy, O_tvalid); end
    repeat (6) cyc();
    checks++; if (trusted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rg_settled got tr=%b busy=%b exp 1 0", trusted, busy); end
  endtask

  task automatic test_reset_mid_packet();
    T_tvalid = 1; T_tdata = 32'h5500_0000; T_tlast = 0; #1; cyc();
    resetn = 0; T_tvalid = 0; cyc();
    resetn = 1; switch_req = 1; switch_to_trusted = 0; #1; cyc();
    switch_req = 0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rp_busy got %b exp 1", busy); end
    repeat (4) cyc();
    checks++; if (trusted !== 1'b1) begin errors++; $display("FAIL rp_pre got %b exp 1", trusted); end
    cyc();
    checks++; if (trusted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rp_flip got tr=%b busy=%b exp 0 0", trusted, busy); end
  endtask

`ifdef NET_ARB_DRAIN_TIMEOUT_EN
  task automatic test_drain_timeout();
    resetn = 0; cyc();
    resetn = 1; T_tvalid = 1; T_tdata = 32'h0000_0011; T_tkeep = 4'hF; T_tlast = 0;
    switch_req = 1; switch_to_trusted = 0; #1; cyc();
    switch_req = 0; T_tvalid = 0;
    for (int d = 1; d <= 8; d++) begin
      #1;
      checks++; if (busy !== 1'b1 || O_tvalid !== 1'b0) begin errors++; $display("FAIL to_drain%0d got busy=%b v=%b exp 1 0", d, busy, O_tvalid); end
      cyc();
    end
    O_tready = 0; #1;
    checks++; if ({O_tvalid, O_tlast} !== 2'b11 || O_tkeep !== 4'h0 || O_tdata !== 32'h0) begin errors++; $display("FAIL to_abort got v=%b l=%b k=%h d=%h exp 1 1 0 0", O_tvalid, O_tlast, O_tkeep, O_tdata); end
    checks++; if (T_tready !== 1'b0 || abort_pulse !== 1'b0) begin errors++; $display("FAIL to_abrdy got T=%b ap=%b exp 0 0", T_tready, abort_pulse); end
    cyc();
    O_tready = 1; #1;
    checks++; if (O_tvalid !== 1'b1 || O_tlast !== 1'b1) begin errors++; $display("FAIL to_hold got v=%b l=%b exp 1 1", O_tvalid, O_tlast); end
    cyc();
    checks++; if (abort_pulse !== 1'b1 || O_tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_pulse got ap=%b v=%b busy=%b exp 1 0 1", abort_pulse, O_tvalid, busy); end
    cyc();
    checks++; if (abort_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_end got %b exp 0", abort_pulse); end
    cyc(); cyc(); cyc();
    checks++; if (trusted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_flip got tr=%b busy=%b exp 0 0", trusted, busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_same_owner();
    test_switch_mid_packet();
    test_gap_request_ignored();
    test_reset_in_gap();
    test_reset_mid_packet();
`ifdef NET_ARB_DRAIN_TIMEOUT_EN
    test_drain_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
